input_port_unit: RTL and testbench

Per-port input stage of the router. It buffers incoming single-flit packets in a 4-entry FIFO and computes the XY route of the head flit. It presents the route to the VC/output allocator as a 3-bit `targ` request and pops the head on grant. Each pop returns one credit upstream. One instance sits in front of each of the five allocator request inputs (`targ1`..`targ5`).

---
 rtl/noc_pkg.sv | 29 ++
 rtl/flit_fifo.sv | 89 ++++++++
 rtl/input_port_unit.sv | 142 ++++++++++++++
 tb/tb_input_port_unit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// -----------------------------------------------------------------------------
// noc_pkg
// Shared definitions for the router datapath (input ports, allocator,
// crossbar): route direction codes, input-port FSM state encoding and the
// default flit width / buffer depth.
// -----------------------------------------------------------------------------
package noc_pkg;

   // Default flit width and per-port buffer depth (buffer depth equals the
   // downstream credit limit, so a well-behaved upstream never overflows it).
   localparam int NOC_DATA_W = 32;
   localparam int NOC_DEPTH  = 4;

   // Route request codes presented to the allocator.
   localparam logic [2:0] DIR_NONE = 3'd0;
   localparam logic [2:0] DIR_E    = 3'd1;
   localparam logic [2:0] DIR_W    = 3'd2;
   localparam logic [2:0] DIR_N    = 3'd3;
   localparam logic [2:0] DIR_S    = 3'd4;
   localparam logic [2:0] DIR_L    = 3'd5;

   // Input-port control states.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ROUTE = 2'd1,
      ST_REQ   = 2'd2
   } port_state_t;

endpackage : noc_pkg

// File: rtl/flit_fifo.sv
// -----------------------------------------------------------------------------
// flit_fifo
// Circular flit buffer with a separate occupancy counter.
//
// Ports:
//   clk    in   clock, rising edge
//   RST    in   synchronous active-high reset (pointers and count only)
//   push   in   write din at the tail (caller guarantees room or a same-cycle pop)
//   pop    in   drop the head entry (caller guarantees non-empty)
//   din    in   flit to write
//   head   out  entry at the read pointer
//   count  out  occupancy, 0..DEPTH
//   full   out  count == DEPTH
//   empty  out  count == 0
// -----------------------------------------------------------------------------
module flit_fifo
   import noc_pkg::*;
#(
   parameter int DATA_W = NOC_DATA_W,
   parameter int DEPTH  = NOC_DEPTH
)(
   input  logic                             clk,
   input  logic                             RST,
   input  logic                             push,
   input  logic                             pop,
   input  logic [DATA_W-1:0]                din,
   output logic [DATA_W-1:0]                head,
   output logic [$clog2(DEPTH+1)-1:0]       count,
   output logic                             full,
   output logic                             empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH-1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
   logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
   logic [CNT_W-1:0]  count_reg,  count_next;

   // Explicit wrap so non-power-of-two depths also work.
   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      count_next  = count_reg;
      if (push) begin
         wr_ptr_next = (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_next = (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + PTR_W'(1);
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({push, pop})
         2'b10:   count_next = count_reg + CNT_ONE;
         2'b01:   count_next = count_reg - CNT_ONE;
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
      end
   end

   // Storage is not reset; stale entries are unreachable once count is 0.
   // At full with a same-cycle pop the write lands on the slot being
   // vacated, which is safe because the consumer has already latched it.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= din;
      end
   end

   assign head  = mem[rd_ptr_reg];
   assign count = count_reg;
   assign full  = (count_reg == CNT_FULL);
   assign empty = (count_reg == '0);

endmodule : flit_fifo

// File: rtl/input_port_unit.sv
// -----------------------------------------------------------------------------
// input_port_unit
// Router input stage: buffers single-flit packets, computes the XY route of
// the head flit and requests the allocator; pops on grant and returns one
// credit per pop.
//
// Ports:
//   clk         in   clock, rising edge
//   RST         in   synchronous active-high reset
//   in_valid    in   upstream writes in_flit this cycle
//   in_flit     in   incoming flit (dest_x/dest_y in the low bits)
//   grant       in   head flit switched this cycle (honoured only in REQ)
//   targ        out  route request: 0 none, 1 E, 2 W, 3 N, 4 S, 5 Local
//   out_flit    out  head flit, valid while targ != 0
//   credit_out  out  one-cycle pulse per pop
//   count       out  buffer occupancy
//   overflow    out  sticky flag, a push was dropped
// -----------------------------------------------------------------------------
module input_port_unit
   import noc_pkg::*;
#(
   parameter int          DATA_W = NOC_DATA_W,
   parameter int          DEPTH  = NOC_DEPTH,
   parameter int          X_W    = 2,
   parameter int          Y_W    = 2,
   parameter int unsigned X_ID   = 0,
   parameter int unsigned Y_ID   = 0
)(
   input  logic                        clk,
   input  logic                        RST,
   input  logic                        in_valid,
   input  logic [DATA_W-1:0]           in_flit,
   input  logic                        grant,
   output logic [2:0]                  targ,
   output logic [DATA_W-1:0]           out_flit,
   output logic                        credit_out,
   output logic [$clog2(DEPTH+1)-1:0]  count,
   output logic                        overflow
);

   localparam int CNT_W = $clog2(DEPTH+1);
   localparam logic [X_W-1:0]   MY_X    = X_W'(X_ID);
   localparam logic [Y_W-1:0]   MY_Y    = Y_W'(Y_ID);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // Dimension-order routing: resolve X first, then Y, else deliver locally.
   function automatic logic [2:0] xy_route(input logic [DATA_W-1:0] flit);
      logic [X_W-1:0] dest_x;
      logic [Y_W-1:0] dest_y;
      dest_x = flit[X_W+Y_W-1:Y_W];
      dest_y = flit[Y_W-1:0];
      if (dest_x > MY_X)      return DIR_E;
      else if (dest_x < MY_X) return DIR_W;
      else if (dest_y > MY_Y) return DIR_N;
      else if (dest_y < MY_Y) return DIR_S;
      else                    return DIR_L;
   endfunction

   port_state_t       state_reg;
   logic [2:0]        targ_reg;
   logic [DATA_W-1:0] out_flit_reg;
   logic              credit_out_reg;
   logic              overflow_reg;

   logic [DATA_W-1:0] head;
   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_full;
   logic              fifo_empty;
   logic              push;
   logic              pop;
   logic              more_after_pop;

   assign pop  = grant && (state_reg == ST_REQ);
   // A pop frees the slot in the same cycle, so a full buffer still accepts.
   assign push = in_valid && (!fifo_full || pop);
   // Only meaningful when popping (count >= 1 then): is anything left after?
   assign more_after_pop = (fifo_count > CNT_ONE) || push;

   flit_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .RST   (RST),
      .push  (push),
      .pop   (pop),
      .din   (in_flit),
      .head  (head),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Control FSM. A push into an empty buffer moves straight to ROUTE on the
   // same edge so the request appears one edge later. After a grant the port
   // always spends one cycle with targ cleared, giving the allocator a
   // registered boundary between consecutive grants.
   always_ff @(posedge clk) begin
      if (RST) begin
         state_reg      <= ST_EMPTY;
         targ_reg       <= DIR_NONE;
         out_flit_reg   <= '0;
         credit_out_reg <= 1'b0;
         overflow_reg   <= 1'b0;
      end else begin
         credit_out_reg <= pop;
         if (in_valid && !push) begin
            overflow_reg <= 1'b1;
         end
         case (state_reg)
            ST_EMPTY: begin
               targ_reg <= DIR_NONE;
               if (!fifo_empty || push) begin
                  state_reg <= ST_ROUTE;
               end
            end
            ST_ROUTE: begin
               targ_reg     <= xy_route(head);
               out_flit_reg <= head;
               state_reg    <= ST_REQ;
            end
            ST_REQ: begin
               if (grant) begin
                  targ_reg  <= DIR_NONE;
                  state_reg <= more_after_pop ? ST_ROUTE : ST_EMPTY;
               end
            end
            default: begin
               targ_reg  <= DIR_NONE;
               state_reg <= ST_EMPTY;
            end
         endcase
      end
   end

   assign targ       = targ_reg;
   assign out_flit   = out_flit_reg;
   assign credit_out = credit_out_reg;
   assign count      = fifo_count;
   assign overflow   = overflow_reg;

endmodule : input_port_unit

// File: tb/tb_input_port_unit.sv
// -----------------------------------------------------------------------------
// tb_input_port_unit
// Self-checking bench for input_port_unit (router at X=1, Y=1). A queue-based
// reference model predicts targ/out_flit/count/credit_out/overflow after every
// clock edge; directed scenarios are followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_input_port_unit;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 4;

   logic              clk = 1'b0;
   logic              RST = 1'b1;
   logic              in_valid = 1'b0;
   logic [DATA_W-1:0] in_flit = '0;
   logic              grant = 1'b0;
   logic [2:0]        targ;
   logic [DATA_W-1:0] out_flit;
   logic              credit_out;
   logic [2:0]        count;
   logic              overflow;

   always #5 clk = ~clk;

   input_port_unit #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .X_W    (2),
      .Y_W    (2),
      .X_ID   (1),
      .Y_ID   (1)
   ) dut (
      .clk        (clk),
      .RST        (RST),
      .in_valid   (in_valid),
      .in_flit    (in_flit),
      .grant      (grant),
      .targ       (targ),
      .out_flit   (out_flit),
      .credit_out (credit_out),
      .count      (count),
      .overflow   (overflow)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Buffer contents as a queue. A stored head is "presented" (requested)
   // once it has been buffered for one whole cycle without being granted;
   // a grant only counts while presented, and the port is silent for the
   // cycle following each grant.
   logic [DATA_W-1:0] mq[$];
   bit                m_pres = 1'b0;
   bit                m_ovf  = 1'b0;
   bit                m_cred = 1'b0;
   int                cred_seen = 0;
   int                pops_obs[$];

   function automatic logic [2:0] route_of(input logic [DATA_W-1:0] f);
      int dx, dy;
      dx = int'(f[3:2]);
      dy = int'(f[1:0]);
      if (dx > 1)      return 3'd1;
      else if (dx < 1) return 3'd2;
      else if (dy > 1) return 3'd3;
      else if (dy < 1) return 3'd4;
      else             return 3'd5;
   endfunction

   function automatic logic [DATA_W-1:0] mk_flit(input int dx, input int dy);
      logic [DATA_W-1:0] r;
      r = $urandom;
      r[3:2] = 2'(dx);
      r[1:0] = 2'(dy);
      return r;
   endfunction

   // One clock cycle: drive inputs, advance the model, check after the edge.
   task automatic cycle(input bit v, input logic [DATA_W-1:0] f, input bit g, input bit rst);
      bit do_pop, do_push, had_head;
      logic [DATA_W-1:0] popped;
      logic [2:0] exp_targ;
      in_valid = v;
      in_flit  = f;
      grant    = g;
      RST      = rst;
      if (rst) begin
         mq.delete();
         m_pres = 1'b0;
         m_ovf  = 1'b0;
         m_cred = 1'b0;
      end else begin
         do_pop   = g && m_pres;
         do_push  = v && ((mq.size() < DEPTH) || do_pop);
         had_head = (mq.size() > 0);
         if (do_pop) begin
            popped = mq.pop_front();
            pops_obs.push_back(int'(targ));
            $display("pop  flit=%h targ=%0d occ_after=%0d", popped, targ, mq.size() + (do_push ? 1 : 0));
         end
         if (do_push) mq.push_back(f);
         if (v && !do_push) m_ovf = 1'b1;
         m_cred = do_pop;
         m_pres = !do_pop && (m_pres || had_head);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      grant    = 1'b0;
      RST      = 1'b0;
      if (credit_out) cred_seen++;
      exp_targ = m_pres ? route_of(mq[0]) : 3'd0;
      check_val("targ", 64'(targ), 64'(exp_targ));
      check_val("count", 64'(count), 64'(mq.size()));
      check_val("credit_out", 64'(credit_out), 64'(m_cred));
      check_val("overflow", 64'(overflow), 64'(m_ovf));
      if (m_pres) check_val("out_flit", 64'(out_flit), 64'(mq[0]));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0);
   endtask

   // Grant whenever a request is up until the buffer is empty (bounded).
   task automatic drain();
      for (int i = 0; i < 40 && mq.size() > 0; i++) cycle(1'b0, '0, m_pres, 1'b0);
      check_val("drain_count", 64'(count), 64'd0);
   endtask

   initial begin
      int exp_seq[4];
      logic [DATA_W-1:0] f;
      exp_seq[0] = 5; exp_seq[1] = 2; exp_seq[2] = 3; exp_seq[3] = 4;

      // Reset and idle.
      cycle(1'b0, '0, 1'b0, 1'b1);
      cycle(1'b0, '0, 1'b0, 1'b1);
      idle(5);

      // Single flit to (3,0): East request, held until grant.
      cycle(1'b1, mk_flit(3, 0), 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b0);
      check_val("east_targ", 64'(targ), 64'd1);
      idle(4);
      cycle(1'b0, '0, 1'b1, 1'b0);
      check_val("east_credit", 64'(credit_out), 64'd1);
      idle(2);

      // Four flits covering Local/West/North/South.
      pops_obs.delete();
      cred_seen = 0;
      cycle(1'b1, mk_flit(1, 1), 1'b0, 1'b0);
      cycle(1'b1, mk_flit(0, 1), 1'b0, 1'b0);
      cycle(1'b1, mk_flit(1, 3), 1'b0, 1'b0);
      cycle(1'b1, mk_flit(1, 0), 1'b0, 1'b0);
      drain();
      idle(1);
      check_val("seq_pops", 64'(pops_obs.size()), 64'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < pops_obs.size()) check_val($sformatf("seq_targ%0d", i), 64'(pops_obs[i]), 64'(exp_seq[i]));
      end
      check_val("seq_credits", 64'(cred_seen), 64'd4);

      // Fill, overflow, then push+grant at full.
      for (int i = 0; i < 5; i++) cycle(1'b1, mk_flit(int'($urandom_range(0, 3)), int'($urandom_range(0, 3))), 1'b0, 1'b0);
      check_val("ovf_set", 64'(overflow), 64'd1);
      idle(1);
      cycle(1'b1, mk_flit(2, 2), 1'b1, 1'b0);
      check_val("full_pushpop_count", 64'(count), 64'd4);
      drain();

      // Pointer wrap: sustained push and grant traffic.
      for (int i = 0; i < 16; i++) cycle(i % 2 == 0, mk_flit(int'($urandom_range(0, 3)), int'($urandom_range(0, 3))), m_pres, 1'b0);
      drain();

      // Reset while requesting with three flits stored, grant ignored.
      for (int i = 0; i < 3; i++) cycle(1'b1, mk_flit(0, 0), 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b1);
      check_val("rst_targ", 64'(targ), 64'd0);
      check_val("rst_credit", 64'(credit_out), 64'd0);
      cycle(1'b1, mk_flit(1, 2), 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b0);
      check_val("post_rst_targ", 64'(targ), 64'd3);
      drain();

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 400; i++) begin
         f = mk_flit(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
         cycle(1'($urandom), f, 1'($urandom), ($urandom_range(0, 63) == 0));
      end
      drain();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_input_port_unit
